// File: rtl/mul16u_dot_acc_if.sv
// Product stream in, group-sum result out.
// master drives products and consumes results; slave is the accumulator.
interface mul16u_dot_acc_if #(
    parameter int ACC_W = 40
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_prod;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [8:0]       out_cnt;
    logic             out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_cnt, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_cnt, out_ovf
    );
endinterface

// File: rtl/mul16u_dot_acc.sv
// Saturating dot-product accumulator behind the approximate multipliers.
// Sums up to LEN products (plus optional bias) per group into one result.
module mul16u_dot_acc #(
    parameter int          LEN     = 16,
    parameter int          ACC_W   = 40,
    parameter int unsigned BIAS    = 622592,
    parameter bit          BIAS_EN = 1'b1
) (
    input logic              clk,
    input logic              rst,
    mul16u_dot_acc_if.slave  bus
);
    localparam logic [ACC_W:0] TERM_BIAS =
        BIAS_EN ? (ACC_W+1)'(BIAS) : '0;
    localparam logic [8:0] LAST_CNT = 9'(LEN - 1);

    logic [ACC_W-1:0] acc;
    logic [8:0]       cnt;
    logic             sat;

    logic             beat;
    logic             term;
    logic [ACC_W:0]   t;
    logic [ACC_W:0]   s;
    logic             flag;
    logic [ACC_W-1:0] res;

    // Accept whenever the output slot is empty or draining; never in reset.
    assign bus.in_ready = ~rst & (~bus.out_valid | bus.out_ready);

    assign beat = bus.in_valid & bus.in_ready;
    assign term = bus.in_last | (cnt == LAST_CNT);

    // Per-beat term and saturating sum, one bit wider to catch the carry.
    always_comb begin
        t    = (ACC_W+1)'(bus.in_prod) + TERM_BIAS;
        s    = {1'b0, acc} + t;
        flag = s[ACC_W] | sat;
        res  = flag ? '1 : s[ACC_W-1:0];
    end

    // Group accumulation and the result register with its handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc           <= '0;
            cnt           <= '0;
            sat           <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_cnt   <= '0;
            bus.out_ovf   <= 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (beat) begin
                if (term) begin
                    bus.out_sum   <= res;
                    bus.out_cnt   <= cnt + 9'd1;
                    bus.out_ovf   <= flag;
                    bus.out_valid <= 1'b1;
                    acc           <= '0;
                    cnt           <= '0;
                    sat           <= 1'b0;
                end else begin
                    acc <= res;
                    sat <= flag;
                    cnt <= cnt + 9'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mul16u_dot_acc.sv
// Directed bench for mul16u_dot_acc across several parameter sets.
// One shared stimulus stream; sel picks which instance receives beats.
module tb_mul16u_dot_acc;
    localparam int unsigned BIAS = 622592;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v = 1'b0;
    logic [31:0] p = '0;
    logic        l = 1'b0;
    logic        ordy = 1'b0;
    int          sel = 0;

    int checks = 0;
    int errors = 0;

    logic        o_valid;
    logic        i_ready;
    logic [47:0] o_sum;
    logic [8:0]  o_cnt;
    logic        o_ovf;

    always #5 clk = ~clk;

    mul16u_dot_acc_if #(.ACC_W(40)) i0 ();
    mul16u_dot_acc_if #(.ACC_W(40)) i1 ();
    mul16u_dot_acc_if #(.ACC_W(40)) i2 ();
    mul16u_dot_acc_if #(.ACC_W(33)) i3 ();
    mul16u_dot_acc_if #(.ACC_W(40)) i4 ();

    assign i0.in_valid = v & (sel == 0);
    assign i1.in_valid = v & (sel == 1);
    assign i2.in_valid = v & (sel == 2);
    assign i3.in_valid = v & (sel == 3);
    assign i4.in_valid = v & (sel == 4);
    assign i0.in_prod = p;
    assign i1.in_prod = p;
    assign i2.in_prod = p;
    assign i3.in_prod = p;
    assign i4.in_prod = p;
    assign i0.in_last = l;
    assign i1.in_last = l;
    assign i2.in_last = l;
    assign i3.in_last = l;
    assign i4.in_last = l;
    assign i0.out_ready = ordy;
    assign i1.out_ready = ordy;
    assign i2.out_ready = ordy;
    assign i3.out_ready = ordy;
    assign i4.out_ready = ordy;

    mul16u_dot_acc #(.LEN(4), .ACC_W(40), .BIAS(BIAS), .BIAS_EN(1'b0))
        d0 (.clk(clk), .rst(rst), .bus(i0));
    mul16u_dot_acc #(.LEN(4), .ACC_W(40), .BIAS(BIAS), .BIAS_EN(1'b1))
        d1 (.clk(clk), .rst(rst), .bus(i1));
    mul16u_dot_acc #(.LEN(2), .ACC_W(40), .BIAS(BIAS), .BIAS_EN(1'b0))
        d2 (.clk(clk), .rst(rst), .bus(i2));
    mul16u_dot_acc #(.LEN(4), .ACC_W(33), .BIAS(BIAS), .BIAS_EN(1'b0))
        d3 (.clk(clk), .rst(rst), .bus(i3));
    mul16u_dot_acc #(.LEN(8), .ACC_W(40), .BIAS(BIAS), .BIAS_EN(1'b0))
        d4 (.clk(clk), .rst(rst), .bus(i4));

    // Observe the selected instance.
    always_comb begin
        o_valid = 1'b0;
        i_ready = 1'b0;
        o_sum   = '0;
        o_cnt   = '0;
        o_ovf   = 1'b0;
        case (sel)
            0: begin
                o_valid = i0.out_valid; i_ready = i0.in_ready;
                o_sum = 48'(i0.out_sum); o_cnt = i0.out_cnt; o_ovf = i0.out_ovf;
            end
            1: begin
                o_valid = i1.out_valid; i_ready = i1.in_ready;
                o_sum = 48'(i1.out_sum); o_cnt = i1.out_cnt; o_ovf = i1.out_ovf;
            end
            2: begin
                o_valid = i2.out_valid; i_ready = i2.in_ready;
                o_sum = 48'(i2.out_sum); o_cnt = i2.out_cnt; o_ovf = i2.out_ovf;
            end
            3: begin
                o_valid = i3.out_valid; i_ready = i3.in_ready;
                o_sum = 48'(i3.out_sum); o_cnt = i3.out_cnt; o_ovf = i3.out_ovf;
            end
            default: begin
                o_valid = i4.out_valid; i_ready = i4.in_ready;
                o_sum = 48'(i4.out_sum); o_cnt = i4.out_cnt; o_ovf = i4.out_ovf;
            end
        endcase
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs,
                       input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [47:0] q[$];
    logic [47:0] ref_acc;
    logic [47:0] exp_sum;
    int          ref_n;
    int          beats;
    int          nres;
    int          budget;

    initial begin
        // Reset state
        sel = 0;
        tick;
        tick;
        chk("rst_valid", 48'(o_valid), 48'd0);
        chk("rst_sum", o_sum, 48'd0);
        chk("rst_cnt", 48'(o_cnt), 48'd0);
        chk("rst_ovf", 48'(o_ovf), 48'd0);
        chk("rst_ready", 48'(i_ready), 48'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 48'(i_ready), 48'd1);

        // 1: four plain beats, LEN=4, no bias
        ordy = 1'b1;
        v = 1'b1;
        p = 32'h0002_0000;
        tick;
        chk("t1_no_early", 48'(o_valid), 48'd0);
        tick;
        tick;
        chk("t1_no_early3", 48'(o_valid), 48'd0);
        tick;
        v = 1'b0;
        chk("t1_valid", 48'(o_valid), 48'd1);
        chk("t1_sum", o_sum, 48'h8_0000);
        chk("t1_cnt", 48'(o_cnt), 48'd4);
        chk("t1_ovf", 48'(o_ovf), 48'd0);
        tick;
        chk("t1_drain", 48'(o_valid), 48'd0);

        // 2: single-beat group with bias, then a fresh group
        sel = 1;
        v = 1'b1;
        p = 32'd0;
        l = 1'b1;
        tick;
        chk("t2_sum", o_sum, 48'(BIAS));
        chk("t2_cnt", 48'(o_cnt), 48'd1);
        p = 32'd5;
        tick;
        chk("t2_next_sum", o_sum, 48'(BIAS) + 48'd5);
        chk("t2_next_cnt", 48'(o_cnt), 48'd1);
        v = 1'b0;
        l = 1'b0;
        tick;
        chk("t2_drain", 48'(o_valid), 48'd0);

        // 3: backpressure on LEN=2
        sel = 2;
        ordy = 1'b0;
        v = 1'b1;
        p = 32'h10;
        tick;
        p = 32'h20;
        tick;
        chk("t3_valid", 48'(o_valid), 48'd1);
        p = 32'h100;
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_ready", 48'(i_ready), 48'd0);
            chk("t3_hold_sum", o_sum, 48'h30);
            chk("t3_hold_valid", 48'(o_valid), 48'd1);
            tick;
        end
        ordy = 1'b1;
        #1;
        chk("t3_release_ready", 48'(i_ready), 48'd1);
        tick;
        chk("t3_after_hs", 48'(o_valid), 48'd0);
        p = 32'h200;
        tick;
        chk("t3_sum2", o_sum, 48'h300);
        chk("t3_cnt2", 48'(o_cnt), 48'd2);
        v = 1'b0;
        tick;

        // 4: saturation on ACC_W=33, then a clean group
        sel = 3;
        v = 1'b1;
        p = 32'hFFFE_0000;
        tick;
        tick;
        tick;
        tick;
        chk("t4_sat_sum", o_sum, 48'h1_FFFF_FFFF);
        chk("t4_sat_ovf", 48'(o_ovf), 48'd1);
        chk("t4_sat_cnt", 48'(o_cnt), 48'd4);
        p = 32'h0002_0000;
        tick;
        l = 1'b1;
        tick;
        chk("t4_clean_sum", o_sum, 48'h4_0000);
        chk("t4_clean_ovf", 48'(o_ovf), 48'd0);
        chk("t4_clean_cnt", 48'(o_cnt), 48'd2);
        v = 1'b0;
        l = 1'b0;
        tick;

        // 5: reset mid-group on LEN=8
        sel = 4;
        v = 1'b1;
        p = 32'h0002_0000;
        tick;
        tick;
        tick;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 48'(o_valid), 48'd0);
        chk("t5_rst_sum", o_sum, 48'd0);
        chk("t5_rst_cnt", 48'(o_cnt), 48'd0);
        chk("t5_rst_ovf", 48'(o_ovf), 48'd0);
        chk("t5_rst_ready", 48'(i_ready), 48'd0);
        tick;
        chk("t5_rst_valid2", 48'(o_valid), 48'd0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (i < 7) chk("t5_no_early", 48'(o_valid), 48'd0);
        end
        chk("t5_valid", 48'(o_valid), 48'd1);
        chk("t5_sum", o_sum, 48'h10_0000);
        chk("t5_cnt", 48'(o_cnt), 48'd8);
        v = 1'b0;
        tick;

        // 6: random bubbles, LEN=4 with bias, reference model
        sel = 1;
        ordy = 1'b1;
        ref_acc = '0;
        ref_n = 0;
        beats = 0;
        nres = 0;
        budget = 0;
        while (beats < 64 && budget < 1000) begin
            v = ($urandom_range(0, 3) != 0);
            p = $urandom;
            if (v) begin
                beats++;
                ref_acc = ref_acc + 48'(p) + 48'(BIAS);
                ref_n++;
                if (ref_n == 4) begin
                    q.push_back(ref_acc);
                    ref_acc = '0;
                    ref_n = 0;
                end
            end
            tick;
            budget++;
            if (o_valid) begin
                nres++;
                exp_sum = (q.size() > 0) ? q.pop_front() : 48'hDEAD;
                chk("t6_sum", o_sum, exp_sum);
                chk("t6_cnt", 48'(o_cnt), 48'd4);
            end
        end
        v = 1'b0;
        tick;
        chk("t6_beats", 48'(beats), 48'd64);
        chk("t6_results", 48'(nres), 48'd16);
        chk("t6_leftover", 48'(q.size()), 48'd0);
        chk("t6_idle", 48'(o_valid), 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul16u_dot_acc.md
# mul16u_dot_acc

Streaming dot-product accumulator placed directly downstream of the 16x16 unsigned approximate multipliers. It accepts one 32-bit product per handshake and sums a group of up to LEN products into a saturating ACC_W-bit accumulator. It optionally adds a per-product bias to cancel the multiplier's systematic underestimate. Each finished sum is emitted through a valid/ready output register.

## Interface
- LEN, 16: products per group; legal range 1..256.
- ACC_W, 40: accumulator and result width; legal range 33..48.
- BIAS, 622592: constant added per accepted product when BIAS_EN=1; equals the mean underestimate of the truncated multiplier.
- BIAS_EN, 1: 1 adds BIAS per product; 0 adds nothing.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_prod/in_last are valid.
- in_ready  out  1  block accepts a product this cycle.
- in_prod  in  32  product word, taken from multiplier output O.
- in_last  in  1  terminates the group early on this beat.
- out_valid  out  1  out_sum/out_cnt/out_ovf are valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  group sum.
- out_cnt  out  9  number of products in the group (1..LEN).
- out_ovf  out  1  group saturated.

## Operation
- Beat = in_valid & in_ready.
- in_ready = ~out_valid | out_ready, combinational. It is forced 0 while rst=1.
- Internal state: acc (ACC_W), cnt (9), sat (1). Output register: out_sum, out_cnt, out_ovf, out_valid.
- Group states:
  - IDLE (cnt=0).
  - ACCUM (0<cnt<LEN).
  - The output register is FULL when out_valid=1.
- Per-beat term t = zero-extend(in_prod) + (BIAS_EN ? BIAS : 0), computed at ACC_W+1 bits.
- Per-beat sum: s = acc + t. If s ≥ 2^ACC_W or sat=1, the result is 2^ACC_W−1 with the saturation flag set. Otherwise the result is s with the flag equal to sat.
- Terminating beat: cnt==LEN−1 or in_last=1.
  - Result, cnt+1 and flag load into out_sum, out_cnt, out_ovf.
  - out_valid←1.
  - acc, cnt, sat ← 0; state returns to IDLE.
- Non-terminating beat: acc, sat ← result and flag; cnt←cnt+1.
- Output handshake: if out_valid & out_ready and no terminating beat occurs that cycle, out_valid←0. If a terminating beat coincides with the handshake, the new result loads and out_valid stays 1 (back-to-back results).
- While out_valid=1 and out_ready=0:
  - in_ready=0.
  - Output fields are held stable.
  - acc and cnt are frozen, so no product is lost.
- in_valid=0 cycles (bubbles) change nothing.
- The low 17 bits of in_prod are not checked; all 32 bits are summed.
- in_last on the first beat of a group yields out_cnt=1.
- in_last together with cnt==LEN−1 is a single termination.

## Timing
- Reset values:
  - out_valid=0, out_sum=0, out_cnt=0, out_ovf=0.
  - acc=0, cnt=0, sat=0.
  - in_ready=0 during reset and 1 in the first cycle after deassertion.
- Reset mid-group discards the partial sum and any held result. The next beat starts a new group with cnt=0.
- Latency: the result is visible on out_valid the cycle after the terminating beat.
- Throughput: one product per cycle sustained when out_ready=1, including across group boundaries. No dead cycle between groups.
- Outputs are registered, except in_ready, which is combinational from out_valid and out_ready.

## Test plan
1. LEN=4, BIAS_EN=0, out_ready=1; four beats of in_prod=0x00020000 -> one cycle after the 4th beat: out_valid=1, out_sum=0x80000, out_cnt=4, out_ovf=0. out_valid=0 the following cycle.
2. BIAS_EN=1; single beat in_prod=0 with in_last=1 -> out_sum=622592, out_cnt=1. The next group starts from 0.
3. LEN=2, out_ready=0 when the result appears, in_valid held high -> in_ready=0 and out_sum held for 5 cycles. Raising out_ready accepts the next product the same cycle; the second group equals the sum of its own two beats.
4. ACC_W=33, LEN=4, BIAS_EN=0; four beats of 0xFFFE0000 -> out_sum=0x1FFFFFFFF, out_ovf=1. The next group of two 0x00020000 gives out_sum=0x40000, out_ovf=0.
5. LEN=8; 3 beats, then rst pulse, then 8 beats of 0x00020000 -> no output before the 8th post-reset beat, then out_sum=0x100000, out_cnt=8. All outputs read 0 during reset.
6. LEN=4, random in_valid bubbles and continuous out_ready=1 over 64 beats -> 16 results, each equal to the reference sum of its 4 products plus 4·BIAS. No beat is dropped or duplicated.
